// File: rtl/irq_sched.sv
`default_nettype none
// ============================================================================
//  Module   : irq_sched
//  Purpose  : Fixed-priority, non-nesting interrupt scheduler that redirects
//             instruction fetch through an int_flag/int_addr pair.
//  Revision : 1.0  initial release
// ============================================================================
module irq_sched #(
    parameter int          N_IRQ      = 8,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter int          VEC_STRIDE = 16
) (
    input  logic             clk,
    input  logic             rst_flag,
    input  logic [N_IRQ-1:0] irq_n,
    input  logic [N_IRQ-1:0] irq_mask,
    input  logic [31:0]      pc,
    input  logic             ctrl_xfer_n,
    input  logic             is_mret,
    output logic             int_flag,
    output logic [31:0]      int_addr,
    output logic [31:0]      epc,
    output logic [3:0]       cause,
    output logic             in_service,
    output logic [N_IRQ-1:0] pending
);

    localparam int               c_SHIFT = $clog2(VEC_STRIDE);
    localparam logic [N_IRQ-1:0] c_ONE   = {{(N_IRQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_IRQ-1:0]   sync1_q, sync2_q, sync3_q;
    logic [N_IRQ-1:0]   pending_q, pending_d;
    logic [31:0]        epc_q, epc_d;
    logic [3:0]         cause_q, cause_d;

    logic [N_IRQ-1:0]   w_fall;
    logic [N_IRQ-1:0]   w_active;
    logic [N_IRQ-1:0]   w_clr;
    logic [3:0]         w_sel;
    logic [31:0]        w_vec;
    logic               w_any;
    logic               w_take;

    // sync3 holds the previous synchronized level so a held-low line pends once
    always_ff @(posedge clk or negedge rst_flag) begin
        if (!rst_flag) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            sync3_q   <= '1;
            pending_q <= '0;
            epc_q     <= '0;
            cause_q   <= '0;
            state_q   <= ST_IDLE;
        end else begin
            sync1_q   <= irq_n;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            pending_q <= pending_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            state_q   <= state_d;
        end
    end

    assign w_fall   = sync3_q & ~sync2_q;
    assign w_active = pending_q & irq_mask;
    assign w_any    = |w_active;

    always_comb begin
        w_sel = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_sel = 4'(i);
            end
        end
    end

    assign w_vec = VEC_BASE + ({28'd0, w_sel} << c_SHIFT);

    always_comb begin
        state_d  = state_q;
        epc_d    = epc_q;
        cause_d  = cause_q;
        w_take   = 1'b0;
        int_flag = 1'b1;
        int_addr = VEC_BASE;
        case (state_q)
            ST_IDLE: begin
                if (w_any) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                int_addr = w_vec;
                if (!w_any) begin
                    state_d = ST_IDLE;
                end else if (ctrl_xfer_n) begin
                    w_take   = 1'b1;
                    int_flag = 1'b0;
                    epc_d    = pc + 32'd4;
                    cause_d  = w_sel;
                    state_d  = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                int_addr = epc_q;
                if (!is_mret) begin
                    int_flag = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // new falls are OR-ed in after the clear so a same-edge set wins
    assign w_clr     = w_take ? (c_ONE << w_sel) : '0;
    assign pending_d = (pending_q & ~w_clr) | w_fall;

    assign epc        = epc_q;
    assign cause      = cause_q;
    assign pending    = pending_q;
    assign in_service = (state_q == ST_SERVICE);

endmodule
`default_nettype wire

// File: tb/tb_irq_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_sched
//  Purpose  : Self-checking bench for irq_sched against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_irq_sched;

    logic        clk = 1'b0;
    logic        rst_flag;
    logic [7:0]  irq_n;
    logic [7:0]  irq_mask;
    logic [31:0] pc;
    logic        ctrl_xfer_n;
    logic        is_mret;
    logic        int_flag;
    logic [31:0] int_addr;
    logic [31:0] epc;
    logic [3:0]  cause;
    logic        in_service;
    logic [7:0]  pending;

    int total = 0;
    int bad   = 0;

    irq_sched #(
        .N_IRQ      (8),
        .VEC_BASE   (32'h0000_0100),
        .VEC_STRIDE (16)
    ) dut (
        .clk         (clk),
        .rst_flag    (rst_flag),
        .irq_n       (irq_n),
        .irq_mask    (irq_mask),
        .pc          (pc),
        .ctrl_xfer_n (ctrl_xfer_n),
        .is_mret     (is_mret),
        .int_flag    (int_flag),
        .int_addr    (int_addr),
        .epc         (epc),
        .cause       (cause),
        .in_service  (in_service),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0]  m_pend;
    logic        m_busy;
    logic        m_armed;
    logic [31:0] m_epc;
    logic [3:0]  m_cause;
    logic [7:0]  h0, h1, h2;

    function automatic logic [3:0] lowest(input logic [7:0] v);
        logic [3:0] r = 4'd0;
        for (int i = 7; i >= 0; i--) if (v[i]) r = 4'(i);
        return r;
    endfunction

    function automatic logic [31:0] vec_of(input logic [3:0] idx);
        return 32'h100 + 32'(idx) * 32'd16;
    endfunction

    always @(posedge clk or negedge rst_flag) begin : model_upd
        logic [7:0] fall, act;
        logic       take;
        if (!rst_flag) begin
            m_pend = 8'h00; m_busy = 1'b0; m_armed = 1'b0;
            m_epc = 32'h0; m_cause = 4'h0;
            h0 = 8'hFF; h1 = 8'hFF; h2 = 8'hFF;
        end else begin
            fall = h2 & ~h1;
            h2 = h1; h1 = h0; h0 = irq_n;
            act  = m_pend & irq_mask;
            take = m_armed && (act != 0) && ctrl_xfer_n;
            if (take) begin
                m_epc   = pc + 32'd4;
                m_cause = lowest(act);
                m_pend[lowest(act)] = 1'b0;
                m_busy  = 1'b1;
                m_armed = 1'b0;
            end else if (m_busy && !is_mret) begin
                m_busy = 1'b0;
            end else if (m_armed && act == 0) begin
                m_armed = 1'b0;
            end else if (!m_armed && !m_busy && act != 0) begin
                m_armed = 1'b1;
            end
            m_pend = m_pend | fall;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        logic [7:0]  act;
        logic        e_flag;
        logic [31:0] e_addr;
        act    = m_pend & irq_mask;
        e_flag = 1'b1;
        e_addr = 32'h100;
        if (m_busy) begin
            e_flag = is_mret;
            e_addr = m_epc;
        end else if (m_armed) begin
            e_flag = !((act != 0) && ctrl_xfer_n);
            e_addr = vec_of(lowest(act));
        end
        check("cyc_int_flag", 32'(int_flag), 32'(e_flag));
        check("cyc_int_addr", int_addr, e_addr);
        check("cyc_epc", epc, m_epc);
        check("cyc_cause", 32'(cause), 32'(m_cause));
        check("cyc_in_service", 32'(in_service), 32'(m_busy));
        check("cyc_pending", 32'(pending), 32'(m_pend));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_flag(input string nm, input int lim);
        int n = 0;
        #1;
        while (int_flag !== 1'b0 && n < lim) begin
            tick();
            n++;
        end
        check(nm, 32'(int_flag), 32'd0);
    endtask

    task automatic do_mret();
        is_mret = 1'b0;
        #1;
        check("mret_flag", 32'(int_flag), 32'd0);
        check("mret_addr", int_addr, m_epc);
        tick();
        is_mret = 1'b1;
        #1;
        check("mret_in_service", 32'(in_service), 32'd0);
    endtask

    initial begin
        rst_flag = 1'b0; irq_n = 8'hFF; irq_mask = 8'hFF; pc = 32'h40;
        ctrl_xfer_n = 1'b1; is_mret = 1'b1;
        repeat (3) tick();
        check("rst_flag", 32'(int_flag), 32'd1);
        check("rst_addr", int_addr, 32'h100);
        check("rst_pending", 32'(pending), 32'd0);
        rst_flag = 1'b1;
        tick();

        // single request, pending latency and take
        irq_n[3] = 1'b0;
        repeat (3) tick();
        check("t1_pending", 32'(pending), 32'h08);
        check("t1_no_flag", 32'(int_flag), 32'd1);
        tick();
        check("t1_take_flag", 32'(int_flag), 32'd0);
        check("t1_take_addr", int_addr, 32'h130);
        tick();
        check("t1_epc", epc, 32'h44);
        check("t1_cause", 32'(cause), 32'd3);
        check("t1_in_service", 32'(in_service), 32'd1);
        check("t1_pending_clr", 32'(pending), 32'd0);
        irq_n[3] = 1'b1;
        do_mret();

        // simultaneous requests, priority order
        irq_n[5] = 1'b0; irq_n[1] = 1'b0;
        wait_flag("t2_first", 8);
        check("t2_first_addr", int_addr, 32'h110);
        tick();
        check("t2_first_cause", 32'(cause), 32'd1);
        irq_n = 8'hFF;
        do_mret();
        wait_flag("t2_second", 8);
        check("t2_second_addr", int_addr, 32'h150);
        tick();
        check("t2_second_cause", 32'(cause), 32'd5);
        do_mret();

        // control transfer stall in ARM
        ctrl_xfer_n = 1'b0;
        irq_n[6] = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 3; i++) begin
            check("t3_stall", 32'(int_flag), 32'd1);
            tick();
        end
        ctrl_xfer_n = 1'b1; pc = 32'h200;
        #1;
        check("t3_take_flag", 32'(int_flag), 32'd0);
        check("t3_take_addr", int_addr, 32'h160);
        tick();
        check("t3_epc", epc, 32'h204);
        irq_n[6] = 1'b1;

        // request during service only pends
        irq_n[0] = 1'b0;
        tick(); tick();
        irq_n[0] = 1'b1;
        tick(); tick();
        check("t4_pending", 32'(pending), 32'h01);
        check("t4_no_flag", 32'(int_flag), 32'd1);
        do_mret();
        wait_flag("t4_next", 4);
        check("t4_next_addr", int_addr, 32'h100);
        tick();
        do_mret();

        // masked request, then unmask; mask removed while armed
        irq_mask = 8'h00; irq_n[2] = 1'b0;
        repeat (5) tick();
        check("t5_pending", 32'(pending), 32'h04);
        check("t5_no_flag", 32'(int_flag), 32'd1);
        irq_n[2] = 1'b1;
        irq_mask = 8'h04;
        wait_flag("t5_unmask", 5);
        check("t5_addr", int_addr, 32'h120);
        tick();
        do_mret();
        irq_mask = 8'hFF; ctrl_xfer_n = 1'b0; irq_n[4] = 1'b0;
        repeat (4) tick();
        irq_mask = 8'h00;
        #1;
        check("t5_unarm", 32'(int_flag), 32'd1);
        tick(); tick();
        ctrl_xfer_n = 1'b1;
        #1;
        check("t5_idle_flag", 32'(int_flag), 32'd1);
        irq_mask = 8'hFF;
        wait_flag("t5_rearm", 4);
        check("t5_rearm_addr", int_addr, 32'h140);
        tick();
        irq_n[4] = 1'b1;
        do_mret();

        // asynchronous reset in service
        irq_n[7] = 1'b0;
        wait_flag("t6_take", 8);
        check("t6_addr", int_addr, 32'h170);
        tick();
        check("t6_in_service", 32'(in_service), 32'd1);
        irq_n[7] = 1'b1;
        #2;
        rst_flag = 1'b0;
        #1;
        check("t6_rst_flag", 32'(int_flag), 32'd1);
        check("t6_rst_addr", int_addr, 32'h100);
        check("t6_rst_epc", epc, 32'd0);
        check("t6_rst_cause", 32'(cause), 32'd0);
        check("t6_rst_in_service", 32'(in_service), 32'd0);
        check("t6_rst_pending", 32'(pending), 32'd0);
        tick(); tick();
        rst_flag = 1'b1;
        tick();

        // epc wraps modulo 2^32
        pc = 32'hFFFF_FFFC; irq_n[1] = 1'b0;
        wait_flag("t7_take", 8);
        tick();
        check("t7_epc_wrap", epc, 32'h0);
        irq_n[1] = 1'b1;
        do_mret();

        // randomized traffic, checked every cycle by the compare process
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(15) == 0) irq_n[b] = ~irq_n[b];
            end
            irq_mask    = ($urandom_range(9) == 0) ? 8'($urandom) : 8'hFF;
            pc          = $urandom;
            ctrl_xfer_n = ($urandom_range(3) != 0);
            is_mret     = ($urandom_range(3) != 0);
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
